cam_capture_rgb332: RTL and testbench

// - Front-end capture stage feeding the dual-port frame buffer write port (addr_in/data_in/regwrite).
// - Samples the OV7670 byte stream (RGB565, 2 bytes/pixel) on the camera pixel clock, packs each pixel to RGB332 and writes one byte per pixel.
// - Frame-synchronised via vsync/href; emits frame_done after each stored frame.

---
 rtl/cam_capture_rgb332.sv | 162 ++++++++++++++++
 tb/tb_cam_capture_rgb332.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_rgb332.sv
// OV7670 RGB565 byte-stream capture, packed to RGB332 and written one byte per pixel to the frame buffer.
// Optional build macro CAM_TEST_PATTERN_EN replaces camera data with 8 vertical colour bars.
module cam_capture_rgb332 #(
    parameter int AW    = 17,
    parameter int DW    = 8,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          busy
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H);
    localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    logic            vsync_q;
    logic            href_q;
    logic            phase;
    logic [5:0]      b1;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [AW-1:0]   line_base;

    logic            vs_fall;
    logic            vs_rise;
    logic            href_rise;
    logic            href_fall;
    logic            cur_phase;
    logic            px_done;
    logic            in_window;
    logic [DW-1:0]   px_pixel;

    always_comb begin
        vs_fall   = vsync_q & ~vsync;
        vs_rise   = ~vsync_q & vsync;
        href_rise = ~href_q & href;
        href_fall = href_q & ~href;
        // the byte arriving with the href rise is always the first byte of a pixel
        cur_phase = href_rise ? 1'b0 : phase;
        px_done   = (state == CAPTURE) && href && cur_phase;
        in_window = (col < COL_MAX) && (row < ROW_MAX);
    end

`ifdef CAM_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(IMG_W / 8);
    logic [CW-1:0] bar;

    always_comb begin
        bar = col / BAR_W;
        case (bar)
            CW'(0):  px_pixel = 8'hFF;
            CW'(1):  px_pixel = 8'hFC;
            CW'(2):  px_pixel = 8'h1F;
            CW'(3):  px_pixel = 8'h1C;
            CW'(4):  px_pixel = 8'hE3;
            CW'(5):  px_pixel = 8'hE0;
            CW'(6):  px_pixel = 8'h03;
            default: px_pixel = 8'h00;
        endcase
    end
`else
    // b1 keeps only R[7:5] and G-high[2:0]; b2 supplies G-low/B bits [4:3]
    always_comb px_pixel = {b1[5:3], b1[2:0], px_data[4:3]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase       <= 1'b0;
            b1          <= '0;
            col         <= '0;
            row         <= '0;
            line_base   <= '0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            px_wr      <= 1'b0;
            frame_done <= 1'b0;

            if (!href)
                phase <= 1'b0;
            else
                phase <= ~cur_phase;

            if (href && !cur_phase)
                b1 <= {px_data[7:5], px_data[2:0]};

            case (state)
                IDLE: begin
                    if (en)
                        state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state     <= CAPTURE;
                        busy      <= 1'b1;
                        row       <= '0;
                        col       <= '0;
                        line_base <= '0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        if (px_done) begin
                            if (in_window) begin
                                px_wr       <= 1'b1;
                                mem_px_addr <= line_base + AW'(col);
                                mem_px_data <= px_pixel;
                            end
                            if (col < COL_MAX)
                                col <= col + CW'(1);
                        end
                        // line_base stops advancing with row so it never exceeds IMG_W*IMG_H
                        if (href_fall) begin
                            col <= '0;
                            if (row < ROW_MAX) begin
                                row       <= row + RW'(1);
                                line_base <= line_base + LINE_STEP;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= en ? WAIT_VS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Directed self-checking bench for cam_capture_rgb332: framing, packing, addressing, en and reset handling.
module tb_cam_capture_rgb332;

    localparam int AW    = 17;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;

`ifdef CAM_TEST_PATTERN_EN
    localparam logic [7:0] K_E3 = 8'hFF;
    localparam logic [7:0] K_1C = 8'hFF;
    localparam logic [7:0] K_03 = 8'hFF;
`else
    localparam logic [7:0] K_E3 = 8'hE3;
    localparam logic [7:0] K_1C = 8'h1C;
    localparam logic [7:0] K_03 = 8'h03;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [7:0]    mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          busy;

    cam_capture_rgb332 #(
        .AW   (AW),
        .DW   (8),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .mem_px_addr(mem_px_addr),
        .mem_px_data(mem_px_data),
        .px_wr      (px_wr),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int stray_wr = 0;
    int line_idx = 0;
    bit exp_cap = 1'b0;

    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    wr_data_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_data_q[$];

    // write recorder; px_wr is only legal while busy
    always @(negedge clk) begin
        if (px_wr === 1'b1) begin
            wr_addr_q.push_back(mem_px_addr);
            wr_data_q.push_back(mem_px_data);
            if (busy !== 1'b1)
                stray_wr++;
        end
        if (frame_done === 1'b1)
            fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_pix(input int c, input logic [7:0] a, input logic [7:0] b);
`ifdef CAM_TEST_PATTERN_EN
        logic [7:0] v;
        case (c / (IMG_W / 8))
            0:       v = 8'hFF;
            1:       v = 8'hFC;
            2:       v = 8'h1F;
            3:       v = 8'h1C;
            4:       v = 8'hE3;
            5:       v = 8'hE0;
            6:       v = 8'h03;
            default: v = 8'h00;
        endcase
        return v;
`else
        return {a[7:5], a[2:0], b[4:3]};
`endif
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        fd_cnt = 0;
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        line_idx = 0;
        tick(2);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] a, input logic [7:0] b, input bit end_frame);
        int npx;
        int nw;
        npx = nbytes / 2;
        nw  = (npx < IMG_W) ? npx : IMG_W;
        if (exp_cap && line_idx < IMG_H) begin
            for (int c = 0; c < nw; c++) begin
                exp_addr_q.push_back(AW'(line_idx * IMG_W + c));
                exp_data_q.push_back(exp_pix(c, a, b));
            end
        end
        line_idx++;
        href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            px_data = (i % 2 == 0) ? a : b;
            tick(1);
        end
        href    = 1'b0;
        px_data = 8'h00;
        if (end_frame)
            vsync = 1'b1;
        tick(3);
    endtask

    task automatic check_writes(input string tag, input int exp_fd);
        int bad;
        int n;
        tick(2);
        chk({tag, "_count"}, wr_addr_q.size(), exp_addr_q.size());
        n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                if (bad == 0)
                    $display("first bad write %0d: addr=%0d data=%0h want addr=%0d data=%0h",
                             i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                bad++;
            end
        end
        chk({tag, "_bad_writes"}, bad, 0);
        chk({tag, "_frame_done"}, fd_cnt, exp_fd);
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        vsync   = 1'b1;
        href    = 1'b0;
        px_data = 8'h00;

        // reset state
        tick(3);
        chk("rst_addr", mem_px_addr, 0);
        chk("rst_data", mem_px_data, 0);
        chk("rst_wr", px_wr, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick(2);

        // A: mixed lines in one frame, latency, packing, long/short lines, vsync rise with pending write
        en = 1'b1;
        tick(2);
        chk("a_wait_busy", busy, 0);
        clear_log();
        exp_cap = 1'b1;
        frame_start();
        chk("a_busy", busy, 1);
        href = 1'b1;
        px_data = 8'hF8;
        tick(1);
        chk("a_lat_b1", px_wr, 0);
        px_data = 8'h1F;
        tick(1);
        chk("a_lat_b2", px_wr, 1);
        chk("a_addr0", mem_px_addr, 0);
        chk("a_data0", mem_px_data, K_E3);
        px_data = 8'hF8;
        tick(1);
        px_data = 8'h1F;
        tick(1);
        chk("a_addr1", mem_px_addr, 1);
        href = 1'b0;
        px_data = 8'h00;
        tick(3);
        exp_addr_q.push_back(AW'(0));
        exp_data_q.push_back(K_E3);
        exp_addr_q.push_back(AW'(1));
        exp_data_q.push_back(K_E3);
        line_idx = 1;
        send_line(2, 8'h07, 8'hE0, 1'b0);
        chk("a_row1_addr", mem_px_addr, 160);
        chk("a_row1_data", mem_px_data, K_1C);
        chk("a_hold_wr", px_wr, 0);
        send_line(2, 8'h00, 8'h18, 1'b0);
        chk("a_row2_addr", mem_px_addr, 320);
        chk("a_row2_data", mem_px_data, K_03);
        send_line(400, 8'hF8, 8'h1F, 1'b0);
        chk("a_long_last", mem_px_addr, 639);
        send_line(101, 8'hF8, 8'h1F, 1'b0);
        chk("a_odd_last", mem_px_addr, 689);
        send_line(4, 8'h07, 8'hE0, 1'b1);
        chk("a_end_busy", busy, 0);
        check_writes("a", 1);

        // B: en dropped mid-frame completes the frame, then stays idle
        clear_log();
        exp_cap = 1'b1;
        frame_start();
        send_line(8, 8'hF8, 8'h1F, 1'b0);
        en = 1'b0;
        send_line(8, 8'h07, 8'hE0, 1'b0);
        frame_end();
        check_writes("b", 1);
        clear_log();
        exp_cap = 1'b0;
        frame_start();
        send_line(8, 8'hF8, 8'h1F, 1'b0);
        chk("b_idle_busy", busy, 0);
        frame_end();
        check_writes("b_idle", 0);

        // C: en raised mid-frame waits for the next vsync fall
        clear_log();
        exp_cap = 1'b0;
        vsync = 1'b0;
        tick(2);
        en = 1'b1;
        tick(2);
        send_line(8, 8'hF8, 8'h1F, 1'b0);
        chk("c_mid_busy", busy, 0);
        frame_end();
        exp_cap = 1'b1;
        frame_start();
        send_line(4, 8'h00, 8'h18, 1'b1);
        check_writes("c", 1);

        // D: reset in the middle of a captured line
        frame_start();
        href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            px_data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
            tick(1);
        end
        chk("d_pre_addr", mem_px_addr, 2);
        chk("d_pre_wr", px_wr, 1);
        rst = 1'b0;
        #1;
        chk("d_rst_addr", mem_px_addr, 0);
        chk("d_rst_data", mem_px_data, 0);
        chk("d_rst_wr", px_wr, 0);
        chk("d_rst_busy", busy, 0);
        chk("d_rst_fd", frame_done, 0);
        href = 1'b0;
        px_data = 8'h00;
        clear_log();
        tick(3);
        rst = 1'b1;
        exp_cap = 1'b0;
        send_line(8, 8'hF8, 8'h1F, 1'b0);
        frame_end();
        exp_cap = 1'b1;
        frame_start();
        send_line(4, 8'h00, 8'h18, 1'b0);
        frame_end();
        check_writes("d", 1);

        // E: full frame plus one surplus line
        clear_log();
        exp_cap = 1'b1;
        frame_start();
        for (int l = 0; l < IMG_H + 1; l++)
            send_line(2 * IMG_W * 2 / 2, 8'hF8, 8'h1F, 1'b0);
        frame_end();
        check_writes("e", 1);
        chk("e_last_addr", mem_px_addr, IMG_W * IMG_H - 1);
        chk("stray_writes", stray_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
